// File: rtl/spi_master_multi_pkg.sv
// spi_master_multi shared types and constants
// state encoding, SPI modes, cs_sel width helper
package spi_master_multi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SETUP,
    TRANSFER,
    HOLD
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// spi_master_multi host/SPI signal bundle
// master = the SPI controller, slave = its user
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) ();

  localparam int CS_W = spi_master_multi_pkg::cs_width(NUM_CS);

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic              keep_cs;
  logic [DATA_W-1:0] data_out;
  logic              new_data;
  logic              busy;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    input  start, data_in, cs_sel, cpol, cpha,
    input  clk_div, keep_cs, miso,
    output data_out, new_data, busy,
    output sck, mosi, cs_n
  );

  modport slave (
    output start, data_in, cs_sel, cpol, cpha,
    output clk_div, keep_cs, miso,
    input  data_out, new_data, busy,
    input  sck, mosi, cs_n
  );

endinterface

// File: rtl/spi_master_multi_sck_gen.sv
// spi_sck_gen: half-period timer for the SPI master
// tick ends each half-period; lead marks leading sck edges
module spi_sck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             xfer,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead
);

  logic [DIV_W-1:0] cnt;
  logic             ph;

  assign tick = en && (cnt == div);
  assign lead = ~ph;

  // count 0..div then wrap, so div at all-ones never overflows
  always_ff @(posedge clk) begin
    if (rst || !en || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  // alternate leading/trailing across the ticks of one transfer
  always_ff @(posedge clk) begin
    if (rst || !xfer) ph <= 1'b0;
    else if (tick)    ph <= ~ph;
  end

endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with runtime mode/divider
// owns FSM, shift registers and chip-select control
module spi_master_multi
  import spi_master_multi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input logic clk,
  input logic rst,
  spi_master_multi_if.master bus
);

  localparam int CS_W = cs_width(NUM_CS);
  localparam int HW   = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_HP = HW'(2 * DATA_W - 1);

  state_t state, state_nx;

  logic [CS_W-1:0]   sel_q, cur_sel;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q, cpha_q, keep_q, cur_cpha;
  logic [DATA_W-1:0] tx_sh, rx_sh, dout_q, cur_data;
  logic [NUM_CS-1:0] cs_q;
  logic [HW-1:0]     hcnt;
  logic              sck_q, mosi_q, nd_q;
  logic              tick, lead, accept, enter_setup;
  logic              xfer_tick, last_hp, sample, shift, held;

  function automatic logic [NUM_CS-1:0] cs_decode(
    input logic [CS_W-1:0] s
  );
    logic [NUM_CS-1:0] v;
    for (int i = 0; i < NUM_CS; i++) v[i] = (32'(s) != i);
    return v;
  endfunction

  spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .xfer (state == TRANSFER),
    .div  (div_q),
    .tick (tick),
    .lead (lead)
  );

  assign accept      = (state == IDLE) && bus.start;
  assign cur_data    = accept ? bus.data_in : tx_sh;
  assign cur_sel     = accept ? bus.cs_sel : sel_q;
  assign cur_cpha    = accept ? bus.cpha : cpha_q;
  assign enter_setup = (state_nx == SETUP) && (state != SETUP);
  assign xfer_tick   = (state == TRANSFER) && tick;
  assign last_hp     = (hcnt == LAST_HP);
  assign sample      = xfer_tick && (lead ^ cpha_q);
  assign shift       = xfer_tick &&
                       (cpha_q ? lead : (!lead && !last_hp));
  assign held        = ~&cs_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state; a different target drops the held select via GAP
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (held && (cs_q != cs_decode(bus.cs_sel)))
            state_nx = GAP;
          else
            state_nx = SETUP;
        end
      end
      GAP:      if (tick) state_nx = SETUP;
      SETUP:    if (tick) state_nx = TRANSFER;
      TRANSFER: if (tick && last_hp) state_nx = HOLD;
      HOLD:     if (tick) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // latched configuration, sck level and chip-selects
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      div_q  <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      keep_q <= 1'b0;
      sck_q  <= 1'b0;
      cs_q   <= '1;
      hcnt   <= '0;
    end else begin
      if (accept) begin
        sel_q  <= bus.cs_sel;
        div_q  <= bus.clk_div;
        cpol_q <= bus.cpol;
        cpha_q <= bus.cpha;
        keep_q <= bus.keep_cs;
      end
      if (accept)                sck_q <= bus.cpol;
      else if (xfer_tick)        sck_q <= ~sck_q;
      else if (state != TRANSFER) sck_q <= cpol_q;
      if (state_nx == GAP) cs_q <= '1;
      if (enter_setup)     cs_q <= cs_decode(cur_sel);
      if (state == HOLD && tick && !keep_q) cs_q <= '1;
      if (state != TRANSFER) hcnt <= '0;
      else if (tick)         hcnt <= hcnt + 1'b1;
    end
  end

  // tx/rx shift paths and the received-word pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      dout_q <= '0;
      mosi_q <= 1'b0;
      nd_q   <= 1'b0;
    end else begin
      nd_q <= 1'b0;
      if (accept) tx_sh <= bus.data_in;
      if (enter_setup && !cur_cpha) begin
        mosi_q <= cur_data[DATA_W-1];
        tx_sh  <= cur_data << 1;
      end
      if (shift) begin
        mosi_q <= tx_sh[DATA_W-1];
        tx_sh  <= tx_sh << 1;
      end
      if (sample) rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
      if (state == HOLD && tick) begin
        dout_q <= rx_sh;
        nd_q   <= 1'b1;
      end
    end
  end

  assign bus.data_out = dout_q;
  assign bus.new_data = nd_q;
  assign bus.busy     = (state != IDLE);
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed + random SPI transfers
// checked against a behavioural slave and timing rules
module tb_spi_master_multi;
  import spi_master_multi_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   held;
  int   cyc = 0;

  spi_master_multi_if #(
    .DATA_W(8), .NUM_CS(5), .DIV_W(4)
  ) bus ();

  spi_master_multi #(
    .DATA_W(8), .NUM_CS(5), .DIV_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model state
  logic [7:0] s_tx;
  logic [7:0] s_rx;
  logic       s_cpol;
  logic       s_cpha;
  logic [4:0] s_cs;
  int         s_n;
  int         s_edges;
  int         s_last;
  int         hp_min;
  int         hp_max;

  // behavioural slave: shifts out s_tx, captures mosi on sample edges
  initial begin
    logic ps;
    logic pb;
    int   g;
    ps = 1'b0;
    pb = 1'b0;
    s_n = 0;
    s_rx = '0;
    s_cs = '1;
    s_edges = 0;
    s_last = 0;
    hp_min = 0;
    hp_max = 0;
    bus.miso = 1'b0;
    forever begin
      @(negedge clk);
      if (pb !== 1'b1 && bus.busy === 1'b1) begin
        s_n = 0;
        s_rx = '0;
        s_edges = 0;
        hp_min = 100000;
        hp_max = 0;
      end else if (pb === 1'b1 && bus.busy === 1'b1 &&
                   bus.sck !== ps) begin
        if (s_edges > 0) begin
          g = cyc - s_last;
          if (g < hp_min) hp_min = g;
          if (g > hp_max) hp_max = g;
        end
        s_last = cyc;
        s_edges++;
        if ((ps == s_cpol) != s_cpha) begin
          if (s_n == 0) s_cs = bus.cs_n;
          s_rx = {s_rx[6:0], bus.mosi};
          s_n++;
        end
      end
      bus.miso = (s_n < 8) ? s_tx[3'(7 - s_n)] : 1'b0;
      ps = bus.sck;
      pb = bus.busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] exp_cs(input logic [2:0] sel);
    return (sel < 3'd5) ? ~(5'd1 << sel) : 5'h1f;
  endfunction

  // one transfer, called during an IDLE cycle; returns in the
  // new_data cycle so the next call starts back-to-back
  task automatic do_xfer(input logic [7:0] d, input logic [2:0] sel,
                         input logic [1:0] mode, input logic [3:0] div,
                         input logic keep, input logic [7:0] sw,
                         input logic hold);
    int h, gap, lat, n;
    logic [4:0] cs_a, cs_b;
    logic sck_a, busy_a, nd_a, busy_all;
    h = int'(div) + 1;
    gap = (held >= 0 && held != int'(sel)) ? 1 : 0;
    lat = 1 + 18 * h + gap * h;
    s_tx = sw;
    s_cpol = mode[1];
    s_cpha = mode[0];
    bus.start = 1'b1;
    bus.data_in = d;
    bus.cs_sel = sel;
    bus.cpol = mode[1];
    bus.cpha = mode[0];
    bus.clk_div = div;
    bus.keep_cs = keep;
    @(posedge clk); #1;
    bus.start = hold;
    bus.data_in = 8'($urandom);
    bus.cs_sel = 3'($urandom);
    bus.cpol = ~mode[1];
    bus.cpha = ~mode[0];
    bus.clk_div = 4'($urandom);
    bus.keep_cs = ~keep;
    cs_a = bus.cs_n;
    sck_a = bus.sck;
    busy_a = bus.busy;
    nd_a = bus.new_data;
    cs_b = '0;
    busy_all = 1'b1;
    n = 1;
    while (!bus.new_data && n < lat + 8) begin
      if (!bus.busy) busy_all = 1'b0;
      if (n == 1 + gap * h) cs_b = bus.cs_n;
      @(posedge clk); #1;
      n++;
    end
    chk("c1_busy", 32'(busy_a), 32'(1'b1));
    chk("c1_new_data", 32'(nd_a), 32'(1'b0));
    chk("c1_sck_idle", 32'(sck_a), 32'(mode[1]));
    chk("c1_cs_n", 32'(cs_a), 32'(gap ? 5'h1f : exp_cs(sel)));
    chk("setup_cs_n", 32'(cs_b), 32'(exp_cs(sel)));
    chk("latency", 32'(n), 32'(lat));
    chk("busy_held", 32'(busy_all), 32'(1'b1));
    chk("nd_busy", 32'(bus.busy), 32'(1'b0));
    chk("data_out", 32'(bus.data_out), 32'(sw));
    chk("slave_mosi", 32'(s_rx), 32'(d));
    chk("sck_edges", 32'(s_edges), 32'(16));
    chk("half_min", 32'(hp_min), 32'(h));
    chk("half_max", 32'(hp_max), 32'(h));
    chk("xfer_cs_n", 32'(s_cs), 32'(exp_cs(sel)));
    chk("nd_sck", 32'(bus.sck), 32'(mode[1]));
    chk("nd_cs_n", 32'(bus.cs_n),
        32'((keep && sel < 3'd5) ? exp_cs(sel) : 5'h1f));
    held = (keep && sel < 3'd5) ? int'(sel) : -1;
  endtask

  initial begin
    int n;
    int nd_cnt;
    rst = 1'b1;
    held = -1;
    bus.start = 1'b0;
    bus.data_in = '0;
    bus.cs_sel = '0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.clk_div = '0;
    bus.keep_cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(bus.cs_n), 32'(5'h1f));
    chk("rst_busy", 32'(bus.busy), 32'(1'b0));
    chk("rst_sck", 32'(bus.sck), 32'(1'b0));
    chk("rst_mosi", 32'(bus.mosi), 32'(1'b0));
    chk("rst_new_data", 32'(bus.new_data), 32'(1'b0));
    chk("rst_data_out", 32'(bus.data_out), 32'(8'h00));
    rst = 1'b0;
    @(posedge clk); #1;

    do_xfer(8'hA5, 3'd0, MODE0, 4'd0, 1'b0, 8'h3C, 1'b0);
    do_xfer(8'h81, 3'd1, MODE3, 4'd3, 1'b0, 8'hC3, 1'b0);
    do_xfer(8'h11, 3'd2, MODE0, 4'd1, 1'b1, 8'h6E, 1'b0);
    do_xfer(8'h22, 3'd2, MODE1, 4'd1, 1'b0, 8'h99, 1'b0);
    do_xfer(8'h33, 3'd1, MODE2, 4'd2, 1'b1, 8'h0F, 1'b0);
    do_xfer(8'h44, 3'd3, MODE0, 4'd2, 1'b0, 8'hF1, 1'b0);
    do_xfer(8'h55, 3'd4, MODE1, 4'd0, 1'b1, 8'h2D, 1'b0);
    do_xfer(8'h66, 3'd6, MODE2, 4'd1, 1'b1, 8'hB4, 1'b0);
    do_xfer(8'h77, 3'd7, MODE3, 4'd0, 1'b0, 8'h5E, 1'b0);
    do_xfer(8'h3A, 3'd0, MODE0, 4'd15, 1'b0, 8'hC5, 1'b0);

    do_xfer(8'hE7, 3'd1, MODE1, 4'd1, 1'b0, 8'h18, 1'b1);
    do_xfer(8'h42, 3'd2, MODE2, 4'd0, 1'b1, 8'hBD, 1'b1);
    do_xfer(8'h9C, 3'd2, MODE0, 4'd2, 1'b0, 8'h63, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_accept", 32'(bus.busy), 32'(1'b0));

    for (int i = 0; i < 10; i++) begin
      do_xfer(8'($urandom), 3'($urandom_range(7, 0)),
              2'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
              1'($urandom_range(1, 0)), 8'($urandom), 1'b0);
    end

    s_tx = 8'hF0;
    s_cpol = 1'b0;
    s_cpha = 1'b0;
    bus.start = 1'b1;
    bus.data_in = 8'hC3;
    bus.cs_sel = 3'd0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.clk_div = 4'd1;
    bus.keep_cs = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (s_n < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reach_bit4", 32'(s_n), 32'(4));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_cs_n", 32'(bus.cs_n), 32'(5'h1f));
    chk("mid_rst_busy", 32'(bus.busy), 32'(1'b0));
    chk("mid_rst_sck", 32'(bus.sck), 32'(1'b0));
    chk("mid_rst_mosi", 32'(bus.mosi), 32'(1'b0));
    chk("mid_rst_nd", 32'(bus.new_data), 32'(1'b0));
    chk("mid_rst_dout", 32'(bus.data_out), 32'(8'h00));
    nd_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.new_data) nd_cnt++;
    end
    chk("mid_rst_no_nd", 32'(nd_cnt), 32'(0));
    held = -1;
    do_xfer(8'h5A, 3'd0, MODE0, 4'd1, 1'b0, 8'hA6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer; legal range 4..32.
REQ-002 Parameter NUM_CS, default 4: chip-select lines; legal range 1..16.
REQ-003 Parameter DIV_W, default 8: width of runtime clock divider.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request transfer; honoured only when busy=0.
REQ-007 data_in  input  DATA_W  word to transmit, MSB first.
REQ-008 cs_sel  input  max(1,$clog2(NUM_CS))  target slave index.
REQ-009 cpol  input  1  SCK idle level.
REQ-010 cpha  input  1  0: sample leading edge; 1: sample trailing edge.
REQ-011 clk_div  input  DIV_W  SCK half-period = clk_div+1 clk cycles.
REQ-012 keep_cs  input  1  1: hold chip-select asserted after transfer (burst).
REQ-013 data_out  output  DATA_W  last received word.
REQ-014 new_data  output  1  one-cycle pulse: data_out updated.
REQ-015 busy  output  1  high while state is not IDLE.
REQ-016 sck, mosi  output  1 each; miso  input  1.
REQ-017 cs_n  output  NUM_CS  active-low chip selects, at most one low.

Function
REQ-018 start, data_in, cs_sel, cpol, cpha, clk_div and keep_cs are latched on the accepting edge; later changes have no effect until the next accepted start.
REQ-019 start while busy=1 is ignored and not queued.
REQ-020 States: IDLE, GAP, SETUP, TRANSFER, HOLD; H = latched clk_div+1 cycles.
REQ-021 IDLE->SETUP on accepted start; IDLE->GAP instead if a chip-select is held low for a different cs_sel.
REQ-022 GAP: all cs_n high for H cycles, then SETUP.
REQ-023 SETUP: cs_n[cs_sel] low and sck=cpol for H cycles; when cpha=0, mosi=data bit DATA_W-1 throughout SETUP.
REQ-024 TRANSFER: 2*DATA_W half-periods of H cycles; sck toggles at each half-period boundary, leaving sck=cpol at the end.
REQ-025 cpha=0: miso is sampled on each leading edge; mosi shifts on each trailing edge except the last.
REQ-026 cpha=1: mosi shifts on each leading edge, starting with the MSB; miso is sampled on each trailing edge.
REQ-027 HOLD: sck=cpol for H cycles, then IDLE; cs_n returns high on HOLD exit unless latched keep_cs=1.
REQ-028 On the first IDLE cycle after HOLD, new_data=1 and data_out holds the received word with the first-sampled bit as MSB.
REQ-029 Latency: start sampled at edge 0 -> new_data high in cycle 1+(2*DATA_W+2)*H; add H when GAP is taken.
REQ-030 A start in the same cycle as new_data is accepted.
REQ-031 cs_sel>=NUM_CS: transfer runs with every cs_n high, and any held chip-select is released first through GAP.
REQ-032 clk_div=0 gives sck=clk/2; clk_div at its maximum value must not cause counter overflow.
REQ-033 busy=1 from the cycle after acceptance through the HOLD cycles.

Reset
REQ-034 rst forces, on the next edge and mid-transfer included: state IDLE, cs_n all ones, sck=0, mosi=0, busy=0, new_data=0, data_out=0, all latched configuration cleared to 0.
REQ-035 A transfer interrupted by rst produces no new_data pulse.

Structure
REQ-036 A shared package holds the state enumeration, mode constants (MODE0..MODE3 as {cpol,cpha}) and a function returning the cs_sel width.
REQ-037 Sub-module spi_sck_gen holds the half-period counter and emits a one-cycle tick at each half-period boundary plus a leading/trailing edge flag; the top level owns the FSM, shift registers and chip-selects.

Verification
REQ-038 Mode 0, DATA_W=8, clk_div=0, data_in=0xA5, slave returns 0x3C -> mosi bits 10100101, data_out=0x3C, new_data in cycle 19.
REQ-039 Mode 3, clk_div=3, data_in=0x81 -> sck idles high, half-period 4 cycles, mosi sampled by slave on rising edges = 0x81.
REQ-040 keep_cs=1 on cs_sel=2 with 0x11, then keep_cs=0 on cs_sel=2 with 0x22 -> cs_n[2] stays low across both words with no GAP, and goes high after the second HOLD.
REQ-041 Held cs_sel=1, next start with cs_sel=3 -> cs_n all high for H cycles, then cs_n[3] low; latency grows by H.
REQ-042 rst asserted at bit 4 of a transfer -> next cycle cs_n all ones, busy=0, sck=0, no new_data; a following transfer of 0x5A completes correctly.
REQ-043 start held high continuously while busy -> exactly one transfer per IDLE window, and a back-to-back start on the new_data cycle is accepted.
